wait_state_mem: RTL and testbench

- Data-memory responder for the CPU dmem request interface (r_v/w_v/adr/data/strobe in, resp/ack out).
- Adds a programmable wait-state latency, so the CPU load/store path is exercised with multi-cycle acknowledge rather than a fixed-latency memory.
- Decodes a tohost exit register, used by the simulation top for program-exit detection.
- Single outstanding request; word-organised storage with byte-strobe writes.

---
 rtl/wait_state_mem.sv | 142 ++++++++++++++
 tb/tb_wait_state_mem.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_state_mem.sv
// Data-memory responder with a programmable wait-state latency and a tohost exit register.
// Serves one request at a time and acknowledges it LATENCY+1 cycles after it is accepted.
module wait_state_mem #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 1024,
  parameter int              LATENCY    = 2,
  parameter logic [XLEN-1:0] TOHOST_ADR = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] adr,
  input  logic [XLEN-1:0] data,
  input  logic [3:0]      strobe,
  output logic [XLEN-1:0] resp,
  output logic            ack,
  output logic            busy,
  output logic            exit_v,
  output logic [XLEN-1:0] exit_code,
  output logic            err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-3:0] DEPTH_W = (XLEN-2)'(DEPTH);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("wait_state_mem: LATENCY must be in 0..15");
  end

  // Handshake: the initiator raises r_v/w_v with adr/data/strobe and holds them
  // stable until ack; a request is taken only in S_IDLE, ack pulses for one cycle,
  // and a request still high during the ack cycle is taken in the next idle cycle.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state, next_state;

  logic [3:0]      cnt;
  logic [XLEN-1:0] lat_adr, lat_data;
  logic [3:0]      lat_strobe;
  logic            lat_write;
  logic [XLEN-1:0] resp_q, exit_code_q;
  logic            exit_v_q, err_q;
  logic [XLEN-1:0] mem [DEPTH];

  logic            accept, entering_ack;
  logic [XLEN-1:0] req_adr, req_data;
  logic [3:0]      req_strobe;
  logic            req_write, req_tohost, req_oor;
  logic [AW-1:0]   req_idx;

  assign accept = (state == S_IDLE) && (r_v || w_v);

  // Live inputs describe the request in its accept cycle, the latched copy afterwards.
  always_comb begin
    req_adr    = lat_adr;
    req_data   = lat_data;
    req_strobe = lat_strobe;
    req_write  = lat_write;
    if (state == S_IDLE) begin
      req_adr    = adr;
      req_data   = data;
      req_strobe = strobe;
      req_write  = w_v;
    end
  end

  assign req_tohost = (req_adr == TOHOST_ADR);
  assign req_oor    = !req_tohost && (req_adr[XLEN-1:2] >= DEPTH_W);
  assign req_idx    = req_adr[AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (r_v || w_v) next_state = (LATENCY == 0) ? S_ACK : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) next_state = S_ACK;
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = (state == S_ACK);
    busy = (state != S_IDLE);
  end

  assign entering_ack = (next_state == S_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      lat_adr     <= '0;
      lat_data    <= '0;
      lat_strobe  <= '0;
      lat_write   <= 1'b0;
      resp_q      <= '0;
      exit_v_q    <= 1'b0;
      exit_code_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        lat_adr    <= adr;
        lat_data   <= data;
        lat_strobe <= strobe;
        lat_write  <= w_v;
        cnt        <= 4'(LATENCY);
        err_q      <= err_q | (r_v & w_v) | req_oor;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // resp is non-zero only during the ack cycle of a read
      resp_q <= '0;
      if (entering_ack) begin
        if (!req_write) begin
          if (req_tohost)   resp_q <= exit_code_q;
          else if (req_oor) resp_q <= XLEN'(32'hDEADBEEF);
          else              resp_q <= mem[req_idx];
        end else if (req_tohost && !exit_v_q) begin
          exit_v_q    <= 1'b1;
          exit_code_q <= req_data;
        end
      end
    end
  end

  // Storage is never reset; writes commit at the end of the ack cycle.
  always_ff @(posedge clk) begin
    if (state == S_ACK && req_write && !req_tohost && !req_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (req_strobe[i]) mem[req_idx][8*i +: 8] <= req_data[8*i +: 8];
      end
    end
  end

  assign resp      = resp_q;
  assign exit_v    = exit_v_q;
  assign exit_code = exit_code_q;
  assign err       = err_q;
endmodule

// File: tb/tb_wait_state_mem.sv
// Bench for wait_state_mem: one instance at LATENCY=2 and one at LATENCY=0, a
// transaction-level reference model checked every cycle, plus directed literal checks.
module tb_wait_state_mem;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_v_a [2];
  logic        w_v_a [2];
  logic [31:0] adr_a [2];
  logic [31:0] data_a [2];
  logic [3:0]  strobe_a [2];
  logic [31:0] resp_a [2];
  logic        ack_a [2];
  logic        busy_a [2];
  logic        exit_v_a [2];
  logic [31:0] exit_code_a [2];
  logic        err_a [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  wait_state_mem #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(LAT_A), .TOHOST_ADR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .r_v(r_v_a[0]), .w_v(w_v_a[0]), .adr(adr_a[0]),
    .data(data_a[0]), .strobe(strobe_a[0]), .resp(resp_a[0]), .ack(ack_a[0]),
    .busy(busy_a[0]), .exit_v(exit_v_a[0]), .exit_code(exit_code_a[0]), .err(err_a[0]));

  wait_state_mem #(.XLEN(32), .DEPTH(DEPTH), .LATENCY(LAT_B), .TOHOST_ADR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .r_v(r_v_a[1]), .w_v(w_v_a[1]), .adr(adr_a[1]),
    .data(data_a[1]), .strobe(strobe_a[1]), .resp(resp_a[1]), .ack(ack_a[1]),
    .busy(busy_a[1]), .exit_v(exit_v_a[1]), .exit_code(exit_code_a[1]), .err(err_a[1]));

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit is_oor(input logic [31:0] a);
    return (a != 32'h0) && ((a >> 2) >= DEPTH);
  endfunction

  // reference model: a transaction counts cycles since accept and ends after its ack cycle
  bit          m_txn [2];
  int          m_cyc [2];
  bit          m_w [2];
  logic [31:0] m_adr [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_strb [2];
  logic [31:0] m_resp [2];
  bit          m_resp_known [2];
  bit          m_exit [2];
  logic [31:0] m_code [2];
  bit          m_err [2];
  logic [31:0] m_mem [2][DEPTH];
  bit          m_val [2][DEPTH];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_txn[k] = 0; m_cyc[k] = 0; m_exit[k] = 0; m_code[k] = '0; m_err[k] = 0;
      m_resp[k] = '0; m_resp_known[k] = 1;
      for (int i = 0; i < DEPTH; i++) m_val[k][i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        bit became_ack;
        int idx;
        became_ack = 0;
        if (!rst_n) begin
          m_txn[k] = 0; m_exit[k] = 0; m_code[k] = '0; m_err[k] = 0;
        end else begin
          if (m_txn[k]) begin
            if (m_cyc[k] == lat_of(k) + 1) begin
              m_txn[k] = 0;
              idx = int'(m_adr[k][11:2]);
              if (m_w[k] && m_adr[k] != 32'h0 && !is_oor(m_adr[k])) begin
                if (m_strb[k] == 4'hF) begin
                  m_mem[k][idx] = m_data[k];
                  m_val[k][idx] = 1;
                end else begin
                  for (int b = 0; b < 4; b++)
                    if (m_strb[k][b]) m_mem[k][idx][8*b +: 8] = m_data[k][8*b +: 8];
                end
              end
            end else begin
              m_cyc[k]++;
              became_ack = (m_cyc[k] == lat_of(k) + 1);
            end
          end else if (r_v_a[k] || w_v_a[k]) begin
            m_txn[k] = 1; m_cyc[k] = 1;
            m_w[k] = w_v_a[k]; m_adr[k] = adr_a[k]; m_data[k] = data_a[k]; m_strb[k] = strobe_a[k];
            if ((r_v_a[k] && w_v_a[k]) || is_oor(adr_a[k])) m_err[k] = 1;
            became_ack = (lat_of(k) == 0);
          end
          if (became_ack) begin
            m_resp_known[k] = 1;
            if (m_w[k]) begin
              m_resp[k] = '0;
              if (m_adr[k] == 32'h0 && !m_exit[k]) begin
                m_exit[k] = 1;
                m_code[k] = m_data[k];
              end
            end else if (m_adr[k] == 32'h0) begin
              m_resp[k] = m_code[k];
            end else if (is_oor(m_adr[k])) begin
              m_resp[k] = 32'hDEADBEEF;
            end else begin
              idx = int'(m_adr[k][11:2]);
              m_resp[k] = m_mem[k][idx];
              m_resp_known[k] = m_val[k][idx];
            end
          end
        end
      end
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          bit exp_ack;
          exp_ack = m_txn[k] && (m_cyc[k] == lat_of(k) + 1);
          chk("ack", k, 32'(ack_a[k]), 32'(exp_ack));
          chk("busy", k, 32'(busy_a[k]), 32'(m_txn[k]));
          chk("exit_v", k, 32'(exit_v_a[k]), 32'(m_exit[k]));
          chk("exit_code", k, exit_code_a[k], m_code[k]);
          chk("err", k, 32'(err_a[k]), 32'(m_err[k]));
          if (!exp_ack)               chk("resp_idle", k, resp_a[k], 32'h0);
          else if (m_resp_known[k])   chk("resp", k, resp_a[k], m_resp[k]);
        end
      end
    end
  end

  // driver tasks
  task automatic do_req(input int k, input bit rv, input bit wv, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] got, output int lat, output int busy_n);
    bit done;
    @(posedge clk); #1;
    r_v_a[k] = rv; w_v_a[k] = wv; adr_a[k] = a; data_a[k] = d; strobe_a[k] = s;
    done = 0; lat = 0; busy_n = 0; got = '0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (busy_a[k]) busy_n++;
      if (ack_a[k]) begin
        done = 1; lat = n; got = resp_a[k];
      end
    end
    r_v_a[k] = 1'b0; w_v_a[k] = 1'b0;
    if (!done) chk("ack_timeout", k, 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", k, 32'(ack_a[k]), 32'd0);
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] got;
    int lat, bn;
    do_req(k, 1'b0, 1'b1, a, d, s, got, lat, bn);
  endtask

  task automatic rd(input int k, input logic [31:0] a, input logic [31:0] expv);
    logic [31:0] got;
    int lat, bn;
    exp_q.push_back(expv);
    do_req(k, 1'b1, 1'b0, a, 32'h0, 4'h0, got, lat, bn);
    chk("rd_data", k, got, exp_q.pop_front());
  endtask

  // stimulus
  initial begin
    logic [31:0] got;
    int lat, bn;
    logic [31:0] tbl [3];
    for (int k = 0; k < 2; k++) begin
      r_v_a[k] = 0; w_v_a[k] = 0; adr_a[k] = '0; data_a[k] = '0; strobe_a[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ack", k, 32'(ack_a[k]), 32'd0);
      chk("rst_busy", k, 32'(busy_a[k]), 32'd0);
      chk("rst_resp", k, resp_a[k], 32'h0);
      chk("rst_exit_v", k, 32'(exit_v_a[k]), 32'd0);
      chk("rst_exit_code", k, exit_code_a[k], 32'h0);
      chk("rst_err", k, 32'(err_a[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // preload and LATENCY=2 read timing
    wr(0, 32'h10, 32'h12345678, 4'hF);
    wr(0, 32'h20, 32'h11223344, 4'hF);
    wr(0, 32'h30, 32'h55667788, 4'hF);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, got, lat, bn);
    chk("lat2_data", 0, got, 32'h12345678);
    chk("lat2_ack_cycles", 0, 32'(lat), 32'd3);
    chk("lat2_busy_cycles", 0, 32'(bn), 32'd3);
    rd(0, 32'h13, 32'h12345678);

    // byte-strobe write, then a strobe-less write that changes nothing
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0101);
    rd(0, 32'h20, 32'h11BB33DD);
    wr(0, 32'h20, 32'h00000000, 4'b0000);
    rd(0, 32'h20, 32'h11BB33DD);

    // tohost: first write sticks, later ones are ignored
    wr(0, 32'h0, 32'h2A, 4'hF);
    chk("exit_v_set", 0, 32'(exit_v_a[0]), 32'd1);
    chk("exit_code_first", 0, exit_code_a[0], 32'h2A);
    wr(0, 32'h0, 32'h7, 4'h0);
    chk("exit_code_kept", 0, exit_code_a[0], 32'h2A);
    rd(0, 32'h0, 32'h2A);

    // out of range and simultaneous read+write
    chk("err_clear", 0, 32'(err_a[0]), 32'd0);
    rd(0, 32'h1000, 32'hDEADBEEF);
    chk("err_oor", 0, 32'(err_a[0]), 32'd1);
    wr(0, 32'h1004, 32'hFFFFFFFF, 4'hF);
    do_req(0, 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 4'hF, got, lat, bn);
    chk("rw_resp", 0, got, 32'h0);
    rd(0, 32'h24, 32'hCAFEF00D);
    chk("err_sticky", 0, 32'(err_a[0]), 32'd1);

    // LATENCY=0 back-to-back reads with the address changed in each ack cycle
    wr(1, 32'h40, 32'h01010101, 4'hF);
    wr(1, 32'h44, 32'h02020202, 4'hF);
    wr(1, 32'h48, 32'h03030303, 4'hF);
    tbl[0] = 32'h01010101; tbl[1] = 32'h02020202; tbl[2] = 32'h03030303;
    do_req(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, got, lat, bn);
    chk("lat0_ack_cycles", 1, 32'(lat), 32'd1);
    @(posedge clk); #1;
    r_v_a[1] = 1'b1; adr_a[1] = 32'h40;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("lat0_ack_pattern", 1, 32'(ack_a[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) begin
        chk("lat0_resp", 1, resp_a[1], tbl[i/2]);
        if (i / 2 < 2) adr_a[1] = 32'h40 + 32'(4 * (i/2 + 1));
      end
    end
    r_v_a[1] = 1'b0;
    @(posedge clk); #1;

    // reset while a write is waiting
    @(posedge clk); #1;
    w_v_a[0] = 1'b1; adr_a[0] = 32'h30; data_a[0] = 32'h99999999; strobe_a[0] = 4'hF;
    @(posedge clk); #1;
    chk("mid_busy", 0, 32'(busy_a[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 0, 32'(busy_a[0]), 32'd0);
    w_v_a[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("mid_rst_ack", 0, 32'(ack_a[0]), 32'd0);
    end
    rst_n = 1'b1;
    chk("post_rst_exit_v", 0, 32'(exit_v_a[0]), 32'd0);
    chk("post_rst_err", 0, 32'(err_a[0]), 32'd0);
    rd(0, 32'h30, 32'h55667788);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
